axi4_wr_arbiter: RTL and testbench
==================================

Name: axi4_wr_arbiter

Overview:
- Round-robin arbiter that shares one downstream AXI4 write address (A) and write data (W) channel pair among NUM_REQ upstream masters.
- Sits in front of the TLP generator decoding stage, so that several write sources feed a single decoder.
- Grants one burst at a time: A handshake first, then all W beats of that burst through wlast, then release.
- Exactly one outstanding burst; no interleaving of W beats between masters.

Parameters:
- NUM_REQ, 2, number of upstream masters (2..8).
- ID_WIDTH, 4, width of aid.
- ADDR_WIDTH, 32, width of aaddr.
- DATA_WIDTH, 256, width of wdata.
- IDX_W, $clog2(NUM_REQ) (minimum 1), width of the grant index; derived, not overridden.

Ports:
- aclk  in  1  clock.
- areset  in  1  asynchronous, active-high reset.
- s_avalid  in  NUM_REQ  per-master A valid.
- s_aready  out  NUM_REQ  per-master A ready.
- s_aid  in  NUM_REQ*ID_WIDTH  packed aid; master i at [i*ID_WIDTH +: ID_WIDTH].
- s_aaddr  in  NUM_REQ*ADDR_WIDTH  packed aaddr.
- s_alen  in  NUM_REQ*8  packed alen.
- s_asize  in  NUM_REQ*3  packed asize.
- s_aburst  in  NUM_REQ*2  packed aburst.
- s_wvalid  in  NUM_REQ  per-master W valid.
- s_wready  out  NUM_REQ  per-master W ready.
- s_wdata  in  NUM_REQ*DATA_WIDTH  packed wdata.
- s_wlast  in  NUM_REQ  per-master wlast.
- m_avalid, m_aid, m_aaddr, m_alen, m_asize, m_aburst  out  1/ID_WIDTH/ADDR_WIDTH/8/3/2  downstream A channel.
- m_aready  in  1  downstream A ready.
- m_wvalid, m_wdata, m_wlast  out  1/DATA_WIDTH/1  downstream W channel.
- m_wready  in  1  downstream W ready.
- grant_idx  out  IDX_W  index of the current or last granted master.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, areset=1):
  - state=IDLE, grant_idx=0, rr_ptr=0.
  - All s_aready/s_wready=0, m_avalid=0, m_wvalid=0, busy=0.
  - Data outputs are don't-care while their valid is low.
- FSM IDLE:
  - If any s_avalid is high, select the first set bit searching from rr_ptr upward with wrap.
  - Register it into grant_idx and go to ADDR.
  - Outputs stay idle in this cycle, so the arbitration latency is 1 cycle from s_avalid to m_avalid.
- FSM ADDR:
  - m_a* = s_a*[grant_idx] (combinational mux from the registered grant).
  - s_aready[grant_idx] = m_aready; every other s_aready=0.
  - On the handshake (m_avalid & m_aready): rr_ptr <= (grant_idx+1) mod NUM_REQ, state <= DATA.
  - If the granted master drops avalid before the handshake (protocol violation), stay in ADDR; never re-arbitrate.
- FSM DATA:
  - m_w* = s_w*[grant_idx]; s_wready[grant_idx] = m_wready; every other s_wready=0; m_avalid=0.
  - On a beat handshake with m_wlast=1: state <= IDLE, and busy falls the next cycle.
  - Non-last beats stay in DATA.
- W before A: W beats that a master presents before its A handshake are ignored (s_wready=0) until DATA.
- Back-to-back: after wlast the FSM always passes through IDLE, so there is a 1-cycle bubble between bursts.
- Fairness: with all masters requesting continuously, grants rotate 0,1,...,NUM_REQ-1,0.
- alen=0: a single beat with wlast=1; ADDR→DATA→IDLE with no special casing.
- Reset mid-burst: immediate return to IDLE, and any partially transferred burst is dropped. The downstream side must be reset together with this block.

Optional Feature:
- Macro: AXI_WR_ARB_BEAT_CHECK_EN.
- With the macro defined:
  - Alen is latched at the A handshake, and a 9-bit beat counter is cleared on entry to DATA.
  - Output port len_err (1 bit, reset 0, sticky until reset) is added.
  - len_err sets when wlast is handshaken with count != latched alen, or when a non-last beat is handshaken with count == latched alen.
  - Forwarding is unchanged; the FSM still exits only on wlast.
- Without the macro: no counter, no len_err port, zero extra logic.

Test Plan:
- Single master: master0 sends aaddr=0x1000, alen=3, then 4 beats with wlast on beat 4 → m_avalid rises 1 cycle after s_avalid; 4 beats forwarded in order; busy falls 1 cycle after the last handshake; grant_idx=0.
- Contention: masters 0 and 1 assert avalid in the same cycle with alen=1 each, both holding requests → order is 0 then 1, then 0 again; s_wready to the non-granted master is never 1.
- Backpressure: m_aready held 0 for 5 cycles, then m_wready toggling 1,0,1,0 → A and W are held stable under stall; no beat is lost or duplicated; rr_ptr advances only on the A handshake.
- Early W: master1 asserts wvalid 3 cycles before avalid → s_wready[1]=0 until the A handshake completes; the data then transfers intact.
- Reset mid-burst: assert areset after beat 2 of a 4-beat burst → all ready/valid outputs are 0 in the same cycle; state=IDLE; grant_idx=0; a new request afterwards goes to master 0.
- With AXI_WR_ARB_BEAT_CHECK_EN: alen=3 burst with wlast on beat 2 → len_err=1 the next cycle and stays 1; FSM returns to IDLE; a following correct burst leaves len_err at 1.

Source files
------------

// File: rtl/axi4_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : axi4_wr_arbiter
//  Purpose  : Round-robin arbiter sharing one downstream AXI4 write address
//             (A) / write data (W) channel pair among NUM_REQ upstream
//             masters. One burst at a time: A handshake, then all W beats up
//             to wlast, then release. No W interleaving between masters.
//  Ports    : aclk, areset (async, active-high)
//             s_a*  / s_w*  : packed per-master A and W channels (master i at
//                             slice [i*W +: W])
//             m_a*  / m_w*  : downstream A and W channels
//             grant_idx     : index of the current or last granted master
//             busy          : high whenever the arbiter is not idle
//             len_err       : (AXI_WR_ARB_BEAT_CHECK_EN only) sticky flag set
//                             when the wlast position disagrees with alen
//  Options  : define AXI_WR_ARB_BEAT_CHECK_EN to add the beat-count checker
//  Revision : 1.0 - initial release
// ============================================================================
module axi4_wr_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 256,
    localparam int IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic [NUM_REQ-1:0]            s_avalid,
    output logic [NUM_REQ-1:0]            s_aready,
    input  logic [NUM_REQ*ID_WIDTH-1:0]   s_aid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] s_aaddr,
    input  logic [NUM_REQ*8-1:0]          s_alen,
    input  logic [NUM_REQ*3-1:0]          s_asize,
    input  logic [NUM_REQ*2-1:0]          s_aburst,
    input  logic [NUM_REQ-1:0]            s_wvalid,
    output logic [NUM_REQ-1:0]            s_wready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] s_wdata,
    input  logic [NUM_REQ-1:0]            s_wlast,
    output logic                          m_avalid,
    output logic [ID_WIDTH-1:0]           m_aid,
    output logic [ADDR_WIDTH-1:0]         m_aaddr,
    output logic [7:0]                    m_alen,
    output logic [2:0]                    m_asize,
    output logic [1:0]                    m_aburst,
    input  logic                          m_aready,
    output logic                          m_wvalid,
    output logic [DATA_WIDTH-1:0]         m_wdata,
    output logic                          m_wlast,
    input  logic                          m_wready,
    output logic [IDX_W-1:0]              grant_idx,
`ifdef AXI_WR_ARB_BEAT_CHECK_EN
    output logic                          len_err,
`endif
    output logic                          busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    localparam logic [IDX_W:0]   c_num_req  = (IDX_W+1)'(NUM_REQ);
    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NUM_REQ-1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDX_W-1:0] r_grant_idx;
    logic [IDX_W-1:0] w_grant_nxt;
    logic [IDX_W-1:0] r_rr_ptr;
    logic [IDX_W-1:0] w_rr_nxt;
    logic [IDX_W-1:0] w_pick;
    logic [IDX_W:0]   w_sum;
    logic             w_found;

    // Per-master views of the packed buses, so the downstream mux is a plain
    // array select on the registered grant.
    logic [ID_WIDTH-1:0]   w_aid    [NUM_REQ];
    logic [ADDR_WIDTH-1:0] w_aaddr  [NUM_REQ];
    logic [7:0]            w_alen   [NUM_REQ];
    logic [2:0]            w_asize  [NUM_REQ];
    logic [1:0]            w_aburst [NUM_REQ];
    logic [DATA_WIDTH-1:0] w_wdata  [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign w_aid[gi]    = s_aid[gi*ID_WIDTH +: ID_WIDTH];
            assign w_aaddr[gi]  = s_aaddr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign w_alen[gi]   = s_alen[gi*8 +: 8];
            assign w_asize[gi]  = s_asize[gi*3 +: 3];
            assign w_aburst[gi] = s_aburst[gi*2 +: 2];
            assign w_wdata[gi]  = s_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // Data paths follow the registered grant unconditionally; they are only
    // meaningful while the matching valid is high.
    assign m_aid     = w_aid[r_grant_idx];
    assign m_aaddr   = w_aaddr[r_grant_idx];
    assign m_alen    = w_alen[r_grant_idx];
    assign m_asize   = w_asize[r_grant_idx];
    assign m_aburst  = w_aburst[r_grant_idx];
    assign m_wdata   = w_wdata[r_grant_idx];
    assign m_wlast   = s_wlast[r_grant_idx];
    assign grant_idx = r_grant_idx;
    assign busy      = (r_state != ST_IDLE);

    // Round-robin pick: first requester at or above rr_ptr, wrapping at
    // NUM_REQ. The index is kept at IDX_W bits so it never leaves range.
    always_comb begin
        w_pick  = r_rr_ptr;
        w_found = 1'b0;
        w_sum   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sum = {1'b0, r_rr_ptr} + (IDX_W+1)'(k);
            if (w_sum >= c_num_req) begin
                w_sum = w_sum - c_num_req;
            end
            if (!w_found && s_avalid[w_sum[IDX_W-1:0]]) begin
                w_found = 1'b1;
                w_pick  = w_sum[IDX_W-1:0];
            end
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state     <= ST_IDLE;
            r_grant_idx <= '0;
            r_rr_ptr    <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_grant_idx <= w_grant_nxt;
            r_rr_ptr    <= w_rr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant_idx;
        w_rr_nxt    = r_rr_ptr;
        s_aready    = '0;
        s_wready    = '0;
        m_avalid    = 1'b0;
        m_wvalid    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Grant is registered here; outputs stay quiet this cycle.
                if (|s_avalid) begin
                    w_grant_nxt = w_pick;
                    w_state_nxt = ST_ADDR;
                end
            end
            ST_ADDR: begin
                // A master that withdraws avalid keeps its grant; no re-arbitration.
                m_avalid              = s_avalid[r_grant_idx];
                s_aready[r_grant_idx] = m_aready;
                if (s_avalid[r_grant_idx] && m_aready) begin
                    w_state_nxt = ST_DATA;
                    w_rr_nxt    = (r_grant_idx == c_last_idx) ? '0
                                                              : r_grant_idx + IDX_W'(1);
                end
            end
            ST_DATA: begin
                m_wvalid              = s_wvalid[r_grant_idx];
                s_wready[r_grant_idx] = m_wready;
                if (s_wvalid[r_grant_idx] && m_wready && s_wlast[r_grant_idx]) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

`ifdef AXI_WR_ARB_BEAT_CHECK_EN
    logic       w_a_hs;
    logic       w_w_hs;
    logic [7:0] r_alen;
    logic [8:0] r_beat_cnt;
    logic       r_len_err;

    assign w_a_hs  = m_avalid & m_aready;
    assign w_w_hs  = m_wvalid & m_wready;
    assign len_err = r_len_err;

    // r_beat_cnt holds the number of beats already accepted in this burst,
    // so the legal wlast position is exactly r_beat_cnt == alen.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_alen     <= '0;
            r_beat_cnt <= '0;
            r_len_err  <= 1'b0;
        end else if (w_a_hs) begin
            r_alen     <= m_alen;
            r_beat_cnt <= '0;
        end else if (w_w_hs) begin
            r_beat_cnt <= r_beat_cnt + 9'd1;
            if (m_wlast != (r_beat_cnt == {1'b0, r_alen})) begin
                r_len_err <= 1'b1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_axi4_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axi4_wr_arbiter
//  Purpose  : Self-checking bench for axi4_wr_arbiter. Randomised masters and
//             downstream readiness, checked every cycle against a
//             transaction-level model of the grant / burst rules.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_axi4_wr_arbiter;

    localparam int N   = 3;
    localparam int IDW = 4;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int IW  = 2;

    logic            aclk = 1'b0;
    logic            areset = 1'b1;
    logic [N-1:0]    s_avalid = '0, s_aready, s_wvalid = '0, s_wready, s_wlast = '0;
    logic [N*IDW-1:0] s_aid = '0;
    logic [N*AW-1:0] s_aaddr = '0;
    logic [N*8-1:0]  s_alen = '0;
    logic [N*3-1:0]  s_asize = '0;
    logic [N*2-1:0]  s_aburst = '0;
    logic [N*DW-1:0] s_wdata = '0;
    logic            m_avalid, m_wvalid, m_wlast, busy;
    logic            m_aready = 1'b0, m_wready = 1'b0;
    logic [IDW-1:0]  m_aid;
    logic [AW-1:0]   m_aaddr;
    logic [7:0]      m_alen;
    logic [2:0]      m_asize;
    logic [1:0]      m_aburst;
    logic [DW-1:0]   m_wdata;
    logic [IW-1:0]   grant_idx;
`ifdef AXI_WR_ARB_BEAT_CHECK_EN
    logic            len_err;
`endif

    axi4_wr_arbiter #(
        .NUM_REQ(N), .ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
    ) u_dut (
        .aclk(aclk), .areset(areset),
        .s_avalid(s_avalid), .s_aready(s_aready), .s_aid(s_aid),
        .s_aaddr(s_aaddr), .s_alen(s_alen), .s_asize(s_asize),
        .s_aburst(s_aburst), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_wdata(s_wdata), .s_wlast(s_wlast),
        .m_avalid(m_avalid), .m_aid(m_aid), .m_aaddr(m_aaddr),
        .m_alen(m_alen), .m_asize(m_asize), .m_aburst(m_aburst),
        .m_aready(m_aready), .m_wvalid(m_wvalid), .m_wdata(m_wdata),
        .m_wlast(m_wlast), .m_wready(m_wready), .grant_idx(grant_idx),
`ifdef AXI_WR_ARB_BEAT_CHECK_EN
        .len_err(len_err),
`endif
        .busy(busy)
    );

    always #5 aclk = ~aclk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- bench-side masters ----------------
    bit          act [N], inw [N], aup [N], wup [N];
    int          beat [N];
    logic [3:0]  b_id [N];
    logic [31:0] b_addr [N];
    logic [7:0]  b_len [N];
    int          b_nb [N];
    bit          b_early [N];
    logic [31:0] b_data [N][8];

    logic [N-1:0] en_mask   = '0;
    int           start_pct = 30;
    int           a_pct     = 50;
    int           rdy_pct   = 60;
    bit           log_en    = 0;
    int           grant_log [$];

    // ---------------- reference model ----------------
    int mdl_owner = -1;   // master owning the downstream port, -1 = idle
    bit mdl_data  = 0;    // owner has completed its A handshake
    int mdl_ptr   = 0;    // next master with priority
    int mdl_grant = 0;    // last granted master
    int mdl_cnt   = 0;
    int mdl_alen  = 0;
    bit mdl_err   = 0;

    task automatic load_burst(input int i, input logic [31:0] addr, input int len,
                              input int nb, input bit early);
        act[i] = 1; inw[i] = 0; aup[i] = 0; wup[i] = 0; beat[i] = 0;
        b_id[i] = 4'($urandom); b_addr[i] = addr; b_len[i] = 8'(len);
        b_nb[i] = nb; b_early[i] = early;
        for (int k = 0; k < 8; k++) b_data[i][k] = $urandom;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (!act[i] && en_mask[i] && $urandom_range(99) < start_pct) begin
                int len;
                len = $urandom_range(7);
                load_burst(i, $urandom, len, len + 1, $urandom_range(3) == 0);
            end
            s_avalid[i] = 1'b0; s_wvalid[i] = 1'b0; s_wlast[i] = 1'b0;
            if (act[i] && !inw[i]) begin
                if (!aup[i]) aup[i] = ($urandom_range(99) < a_pct);
                s_avalid[i] = aup[i];
                s_wvalid[i] = b_early[i];
                s_wdata[i*DW +: DW] = b_data[i][0];
                s_wlast[i] = (b_nb[i] == 1);
            end else if (act[i] && inw[i]) begin
                if (!wup[i]) wup[i] = ($urandom_range(3) != 0);
                s_wvalid[i] = wup[i];
                s_wdata[i*DW +: DW] = b_data[i][beat[i]];
                s_wlast[i] = (beat[i] == b_nb[i] - 1);
            end
            s_aid[i*IDW +: IDW]  = b_id[i];
            s_aaddr[i*AW +: AW]  = b_addr[i];
            s_alen[i*8 +: 8]     = b_len[i];
            s_asize[i*3 +: 3]    = 3'(i + 2);
            s_aburst[i*2 +: 2]   = 2'(i);
        end
        m_aready = ($urandom_range(99) < rdy_pct);
        m_wready = ($urandom_range(99) < rdy_pct);
    endtask

    task automatic check_outputs();
        logic [N-1:0] ea, ew;
        bit emav, emwv;
        int o;
        ea = '0; ew = '0; emav = 0; emwv = 0; o = mdl_owner;
        if (o >= 0) begin
            if (!mdl_data) begin emav = s_avalid[o]; ea[o] = m_aready; end
            else           begin emwv = s_wvalid[o]; ew[o] = m_wready; end
        end
        check_eq("busy", busy, (o >= 0));
        check_eq("s_aready", s_aready, ea);
        check_eq("s_wready", s_wready, ew);
        check_eq("m_avalid", m_avalid, emav);
        check_eq("m_wvalid", m_wvalid, emwv);
        check_eq("grant_idx", grant_idx, mdl_grant);
        if (emav) begin
            check_eq("m_aid", m_aid, b_id[o]);
            check_eq("m_aaddr", m_aaddr, b_addr[o]);
            check_eq("m_alen", m_alen, b_len[o]);
            check_eq("m_asize", m_asize, o + 2);
            check_eq("m_aburst", m_aburst, o);
        end
        if (emwv) begin
            check_eq("m_wdata", m_wdata, b_data[o][beat[o]]);
            check_eq("m_wlast", m_wlast, (beat[o] == b_nb[o] - 1));
        end
`ifdef AXI_WR_ARB_BEAT_CHECK_EN
        check_eq("len_err", len_err, mdl_err);
`endif
        if (log_en && m_avalid && m_aready) grant_log.push_back(int'(grant_idx));
    endtask

    task automatic advance();
        int o;
        o = mdl_owner;
        if (o < 0) begin
            for (int k = 0; k < N; k++) begin
                if (mdl_owner < 0 && s_avalid[(mdl_ptr + k) % N]) mdl_owner = (mdl_ptr + k) % N;
            end
            if (mdl_owner >= 0) begin mdl_grant = mdl_owner; mdl_data = 0; end
        end else if (!mdl_data) begin
            if (s_avalid[o] && m_aready) begin
                mdl_data = 1; mdl_ptr = (o + 1) % N; mdl_cnt = 0; mdl_alen = b_len[o];
            end
        end else if (s_wvalid[o] && m_wready) begin
            bit lastb;
            lastb = (beat[o] == b_nb[o] - 1);
            if (lastb ? (mdl_cnt != mdl_alen) : (mdl_cnt == mdl_alen)) mdl_err = 1;
            mdl_cnt++;
            if (lastb) mdl_owner = -1;
        end
        // Masters follow the handshakes the DUT actually offers.
        for (int i = 0; i < N; i++) begin
            if (act[i] && !inw[i] && s_avalid[i] && s_aready[i]) begin
                inw[i] = 1; aup[i] = 0; wup[i] = b_early[i]; beat[i] = 0;
            end else if (act[i] && inw[i] && s_wvalid[i] && s_wready[i]) begin
                beat[i]++; wup[i] = 0;
                if (beat[i] == b_nb[i]) begin act[i] = 0; inw[i] = 0; end
            end
        end
    endtask

    task automatic step();
        @(posedge aclk); #1;
        drive();
        #1;
        check_outputs();
        advance();
    endtask

    function automatic bit pending();
        bit p;
        p = (mdl_owner >= 0);
        for (int i = 0; i < N; i++) p |= act[i];
        return p;
    endfunction

    task automatic drain(input int limit);
        int c;
        c = 0;
        en_mask = '0;
        while (pending() && c < limit) begin step(); c++; end
        check_eq("drain_done", pending(), 0);
    endtask

    task automatic apply_reset();
        areset = 1'b1;
        #1;
        check_eq("rst_s_aready", s_aready, 0);
        check_eq("rst_s_wready", s_wready, 0);
        check_eq("rst_m_avalid", m_avalid, 0);
        check_eq("rst_m_wvalid", m_wvalid, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_grant_idx", grant_idx, 0);
`ifdef AXI_WR_ARB_BEAT_CHECK_EN
        check_eq("rst_len_err", len_err, 0);
`endif
        for (int i = 0; i < N; i++) begin act[i] = 0; inw[i] = 0; aup[i] = 0; wup[i] = 0; end
        s_avalid = '0; s_wvalid = '0;
        mdl_owner = -1; mdl_data = 0; mdl_ptr = 0; mdl_grant = 0; mdl_err = 0;
        repeat (2) @(posedge aclk);
        #1 areset = 1'b0;
    endtask

    initial begin
        int c;
        int exp_order [4];
        exp_order = '{0, 1, 2, 0};

        apply_reset();

        // Single master, then early W on master 1.
        en_mask = '0; rdy_pct = 100; a_pct = 100;
        load_burst(0, 32'h1000, 3, 4, 0);
        drain(100);
        a_pct = 0;
        load_burst(1, 32'h2000, 2, 3, 1);
        repeat (3) step();
        a_pct = 100;
        drain(100);

        // Contention from reset: rotation must be 0,1,2,0.
        apply_reset();
        log_en = 1; start_pct = 100; a_pct = 100; rdy_pct = 100; en_mask = '1;
        c = 0;
        while (grant_log.size() < 4 && c < 400) begin step(); c++; end
        log_en = 0;
        drain(200);
        check_eq("rr_count", grant_log.size() >= 4, 1);
        for (int k = 0; k < 4 && k < grant_log.size(); k++)
            check_eq($sformatf("rr_order%0d", k), grant_log[k], exp_order[k]);

        // Random traffic with moderate, then heavy backpressure.
        start_pct = 30; a_pct = 50; rdy_pct = 60; en_mask = '1;
        repeat (1500) step();
        rdy_pct = 15;
        repeat (500) step();
        rdy_pct = 60;
        drain(1000);

        // Reset in the middle of a 4-beat burst.
        rdy_pct = 100; a_pct = 100;
        load_burst(0, 32'h1000, 3, 4, 0);
        c = 0;
        while (beat[0] < 2 && c < 50) begin step(); c++; end
        check_eq("mid_beat_reached", beat[0], 2);
        apply_reset();
        load_burst(1, 32'h3000, 1, 2, 0);
        load_burst(0, 32'h4000, 1, 2, 0);
        step(); step();
        check_eq("post_rst_grant", grant_idx, 0);
        drain(100);

`ifdef AXI_WR_ARB_BEAT_CHECK_EN
        // wlast on beat 2 of an alen=3 burst, then a well-formed burst.
        load_burst(2, 32'h5000, 3, 2, 0);
        drain(100);
        check_eq("len_err_set", len_err, 1);
        load_burst(1, 32'h6000, 1, 2, 0);
        drain(100);
        check_eq("len_err_sticky", len_err, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
